ref_cmd_seq: RTL
================

Name: ref_cmd_seq

Overview:
Command-side responder to the refresh checker. It consumes the checker's ref_set/ref_end/wen/ren and drives the SDRAM command pins for PRECHARGE-ALL and AUTO-REFRESH bursts. It returns trca_end, StRef and req_ack to the checker. It also arbitrates between refresh and host read/write starts, and sits between the refresh checker and the read/write datapath in the DDR controller.

Parameters:
RW_CYC, 4, cycles the sequencer stays busy after accepting a read or write (burst occupancy), minimum 1.

Ports:
mclk  input  1  controller clock; all logic on rising edge.
s_resetn  input  1  reset, asynchronous, active-low.
init_done  input  1  SDRAM initialisation complete.
ref_set  input  1  level; refresh due, held until ref_end.
ref_end  input  1  last refresh of burst; sampled only in the trca_end cycle.
wen  input  1  host write pending.
ren  input  1  host read pending.
sdr_trp  input  3  precharge-to-refresh cycles (0 treated as 1).
sdr_trca  input  4  refresh-to-next-command cycles (0 treated as 1).
trca_end  output  1  one-cycle pulse when tRC after an AUTO-REFRESH expires.
StRef  output  1  high from the AUTO-REFRESH cycle through the trca_end cycle inclusive.
req_ack  output  1  one-cycle pulse on acceptance of a read or write.
wr_go  output  1  one-cycle pulse with req_ack for a write.
rd_go  output  1  one-cycle pulse with req_ack for a read.
ref_busy  output  1  high in every state except IDLE and RW_BUSY.
sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  output  1 each  registered SDRAM command.
sdr_a10  output  1  1 during PRECHARGE (all banks), else 0.

Behaviour:
- Reset (s_resetn low, async): state IDLE; counters 0; trca_end/StRef/req_ack/wr_go/rd_go/ref_busy = 0; cs_n/ras_n/cas_n/we_n = 1 (deselect); sdr_a10 = 0.
- Commands, all registered, valid the cycle after the state is entered:
  - NOP: cs=0, ras=1, cas=1, we=1.
  - PRE: 0,0,1,0 with a10=1.
  - AREF: 0,0,0,1.
  - Every other cycle after reset is NOP once init_done=1, and deselect while init_done=0.
- States: IDLE, PRE, WAIT_RP, AREF, WAIT_RC, RW_BUSY.
- IDLE:
  - With init_done=0, the block stays in IDLE and ignores all requests.
  - Priority is ref_set over wen over ren.
  - ref_set=1 -> PRE.
  - Otherwise wen=1 -> pulse req_ack+wr_go, then RW_BUSY.
  - Otherwise ren=1 -> pulse req_ack+rd_go, then RW_BUSY.
  - wen and ren both high: write wins.
- PRE: one cycle. Load rp counter with max(sdr_trp,1)-1, then go to WAIT_RP; if the loaded value is 0, go directly to AREF.
- WAIT_RP: NOP, decrement; at 0 -> AREF. PRE-to-AREF spacing = max(sdr_trp,1) cycles.
- AREF: one cycle. StRef rises. Load rc counter with max(sdr_trca,1)-1, then go to WAIT_RC.
- WAIT_RC: NOP.
  - When counter = 0: trca_end=1 that cycle; StRef still 1.
  - Otherwise decrement.
  - AREF-to-trca_end spacing = max(sdr_trca,1) cycles.
- At trca_end:
  - ref_end=1 or ref_set=0 -> IDLE; StRef falls next cycle.
  - Otherwise -> AREF directly with no re-precharge; StRef stays 1 continuously.
- RW_BUSY: RW_CYC cycles, NOP; wen/ren/ref_set ignored; then IDLE.
  - A ref_set arriving during RW_BUSY is serviced on return to IDLE, ahead of any pending rw.
- Back-to-back rw: a new request is accepted in the first IDLE cycle after RW_BUSY. The minimum accept spacing is RW_CYC+1 cycles.
- init_done falling mid-refresh: the current PRE/AREF/WAIT_RC sequence completes, then the block returns to IDLE and holds.
- sdr_trp/sdr_trca are sampled only at counter load; changes mid-count have no effect.
- Counter widths are 3 and 4 bits; counters never wrap because they only load-and-count-down.

Test Plan:
1. Reset mid-WAIT_RC (sdr_trca=8, pull s_resetn low 3 cycles after AREF) -> all outputs immediately at reset values, cs_n=1, StRef=0.
2. init_done=1, sdr_trp=2, sdr_trca=6, ref_set high, ref_end high at first trca_end:
   - PRE at cycle t+1 with a10=1;
   - AREF at t+3;
   - StRef high t+3..t+9;
   - trca_end pulses at t+9;
   - IDLE thereafter with NOPs.
3. Same as 2 but ref_end only at the third trca_end -> three AREFs spaced 7 cycles apart, one PRE only, StRef continuously high, exactly three trca_end pulses.
4. wen=1 with ref_set=0, RW_CYC=4 -> req_ack and wr_go pulse one cycle; a second wen held high gets its next req_ack exactly 5 cycles later; rd_go stays 0.
5. wen and ref_set rise in the same IDLE cycle -> PRE issued, no req_ack until after trca_end with ref_end; then req_ack+wr_go in the first IDLE cycle.
6. sdr_trp=0, sdr_trca=0 -> PRE then AREF on the next cycle, trca_end one cycle after AREF; init_done=0 with ren=1 -> no req_ack, command pins deselected.

Source files
------------

// File: rtl/ref_cmd_seq.sv
// Refresh command sequencer: issues PRECHARGE-ALL / AUTO-REFRESH bursts for the
// refresh checker and arbitrates refresh against host read/write starts.
module ref_cmd_seq #(
  parameter int unsigned RW_CYC = 4
) (
  input  logic       mclk,
  input  logic       s_resetn,
  input  logic       init_done,
  input  logic       ref_set,
  input  logic       ref_end,
  input  logic       wen,
  input  logic       ren,
  input  logic [2:0] sdr_trp,
  input  logic [3:0] sdr_trca,
  output logic       trca_end,
  output logic       StRef,
  output logic       req_ack,
  output logic       wr_go,
  output logic       rd_go,
  output logic       ref_busy,
  output logic       sdr_cs_n,
  output logic       sdr_ras_n,
  output logic       sdr_cas_n,
  output logic       sdr_we_n,
  output logic       sdr_a10
);

  localparam int unsigned RP_W  = 3;
  localparam int unsigned RC_W  = 4;
  localparam int unsigned RW_W  = (RW_CYC > 1) ? $clog2(RW_CYC) : 1;
  localparam int unsigned CMD_W = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_DES  = 4'b1111;
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_WAIT_RP = 3'd2,
    S_AREF    = 3'd3,
    S_WAIT_RC = 3'd4,
    S_RW_BUSY = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [RP_W-1:0]  rp_q, rp_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [RW_W-1:0]  rw_q, rw_d;

  logic [RP_W-1:0]  trp_m1;
  logic [RC_W-1:0]  trca_m1;

  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             a10_d, stref_d, trca_end_d, ack_d, wr_d, rd_d, busy_d;

  // Zero-programmed timings behave as one cycle.
  always_comb begin
    trp_m1  = (sdr_trp  == '0) ? '0 : RP_W'(sdr_trp  - 3'd1);
    trca_m1 = (sdr_trca == '0) ? '0 : RC_W'(sdr_trca - 4'd1);
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    rc_d    = rc_q;
    rw_d    = rw_q;
    ack_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_done) begin
          if (ref_set) begin
            state_d = S_PRE;
          end else if (wen) begin
            ack_d   = 1'b1;
            wr_d    = 1'b1;
            rw_d    = RW_W'(RW_CYC - 1);
            state_d = S_RW_BUSY;
          end else if (ren) begin
            ack_d   = 1'b1;
            rd_d    = 1'b1;
            rw_d    = RW_W'(RW_CYC - 1);
            state_d = S_RW_BUSY;
          end
        end
      end
      S_PRE: begin
        rp_d    = trp_m1;
        state_d = (trp_m1 == '0) ? S_AREF : S_WAIT_RP;
      end
      S_WAIT_RP: begin
        rp_d = RP_W'(rp_q - 3'd1);
        if (rp_d == '0) state_d = S_AREF;
      end
      S_AREF: begin
        rc_d    = trca_m1;
        state_d = S_WAIT_RC;
      end
      S_WAIT_RC: begin
        if (rc_q == '0) begin
          // Burst continues without re-precharge unless ended or init lost.
          state_d = (ref_end || !ref_set || !init_done) ? S_IDLE : S_AREF;
        end else begin
          rc_d = RC_W'(rc_q - 4'd1);
        end
      end
      S_RW_BUSY: begin
        if (rw_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rw_d = RW_W'(rw_q - 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered so they line up with the state being entered.
    cmd_d = init_done ? CMD_NOP : CMD_DES;
    a10_d = 1'b0;
    case (state_d)
      S_PRE:   begin cmd_d = CMD_PRE; a10_d = 1'b1; end
      S_AREF:  cmd_d = CMD_AREF;
      default: ;
    endcase
    stref_d    = (state_d == S_AREF) || (state_d == S_WAIT_RC);
    trca_end_d = (state_d == S_WAIT_RC) && (rc_d == '0);
    busy_d     = (state_d != S_IDLE) && (state_d != S_RW_BUSY);
  end

  // State and counter registers.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      rc_q    <= '0;
      rw_q    <= '0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      rc_q    <= rc_d;
      rw_q    <= rw_d;
    end
  end

  // Output registers; reset drives deselect on the command pins.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      cmd_q    <= CMD_DES;
      sdr_a10  <= 1'b0;
      StRef    <= 1'b0;
      trca_end <= 1'b0;
      req_ack  <= 1'b0;
      wr_go    <= 1'b0;
      rd_go    <= 1'b0;
      ref_busy <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      sdr_a10  <= a10_d;
      StRef    <= stref_d;
      trca_end <= trca_end_d;
      req_ack  <= ack_d;
      wr_go    <= wr_d;
      rd_go    <= rd_d;
      ref_busy <= busy_d;
    end
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;

endmodule
